mem_stage_pl: RTL and testbench

Parametrised MIPS memory-access stage with MEM/WB pipeline register, the successor to the fixed 32-bit word-only stage. Adds byte/halfword loads and stores with sign/zero extension, misalignment detection, a configurable memory read latency with pipeline stall handshake, and forwarded store data. Sits between the EX/MEM register and the write-back stage; its internal data RAM is a behavioural byte-enabled array.

---
 rtl/mem_stage_pl_if.sv | 34 +++
 rtl/mem_stage_pl.sv | 104 ++++++++++
 tb/tb_mem_stage_pl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pl_if.sv
// mem_stage_pl_if: EX/MEM-side inputs and MEM/WB register outputs of the memory stage.
interface mem_stage_pl_if #(
    parameter int WB_W = 2
);
    logic            in_valid;
    logic [WB_W-1:0] wbi;
    logic [4:0]      regaddr;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      size;
    logic            sign_ext;
    logic [31:0]     addr;
    logic [31:0]     store_data;
    logic            forw;
    logic [31:0]     result_from_mem;
    logic            stall;
    logic            out_valid;
    logic [WB_W-1:0] wbo;
    logic [31:0]     datafrommem;
    logic [31:0]     datafromimm;
    logic [4:0]      regaddrout;
    logic            misaligned;

    modport master (
        output in_valid, wbi, regaddr, mem_read, mem_write, size, sign_ext, addr,
               store_data, forw, result_from_mem,
        input  stall, out_valid, wbo, datafrommem, datafromimm, regaddrout, misaligned
    );
    modport slave (
        input  in_valid, wbi, regaddr, mem_read, mem_write, size, sign_ext, addr,
               store_data, forw, result_from_mem,
        output stall, out_valid, wbo, datafrommem, datafromimm, regaddrout, misaligned
    );
endinterface

// File: rtl/mem_stage_pl.sv
// mem_stage_pl: MIPS memory stage with byte-enabled data RAM, variable load latency and MEM/WB register.
module mem_stage_pl #(
    parameter int ADDR_W  = 13,
    parameter int WB_W    = 2,
    parameter int LATENCY = 1
) (
    input logic           clk,
    input logic           reset,
    mem_stage_pl_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_e;
    localparam logic [1:0] CNT_INIT = 2'(LATENCY > 1 ? LATENCY - 2 : 0);
    localparam bit MULTI = LATENCY > 1;

    logic [31:0] ram [2**ADDR_W];
    state_e state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic out_valid_q, out_valid_d, mis_q, mis_d;
    logic [WB_W-1:0] wbo_q, wbo_d;
    logic [31:0] dfm_q, dfm_d, dfi_q, dfi_d;
    logic [4:0] ra_q, ra_d;

    logic [ADDR_W-1:0] widx;
    logic [1:0] lane;
    logic mis, slow_load, cap;
    logic [31:0] wd, wdata, rword, ld;
    logic [15:0] rsh;
    logic [3:0] be;

    assign widx = bus.addr[ADDR_W+1:2];
    assign lane = bus.addr[1:0];
    assign mis = (bus.mem_read | bus.mem_write) &
                 ((bus.size == 2'b01 & lane[0]) | (bus.size[1] & lane != 2'b00));
    assign slow_load = MULTI & bus.in_valid & bus.mem_read & ~mis;

    // Sub-word stores replicate the data across lanes; the byte enables pick the target.
    assign wd = bus.forw ? bus.result_from_mem : bus.store_data;
    assign be = bus.size[1] ? 4'b1111 : bus.size[0] ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b0001 << lane;
    assign wdata = bus.size[1] ? wd : bus.size[0] ? {2{wd[15:0]}} : {4{wd[7:0]}};

    assign rword = ram[widx];
    assign rsh = 16'(rword >> {lane, 3'b000});
    assign ld = bus.size[1] ? rword :
                bus.size[0] ? {{16{bus.sign_ext & rsh[15]}}, rsh} :
                              {{24{bus.sign_ext & rsh[7]}}, rsh[7:0]};

    always_ff @(posedge clk)
        if (!reset && state_q == IDLE && bus.in_valid && bus.mem_write && !mis)
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];

    // Upstream holds the load stable while waiting, so the result is read in the capture cycle.
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        cap = 1'b0;
        if (state_q == IDLE) begin
            if (slow_load) begin
                state_d = WAIT;
                cnt_d = CNT_INIT;
            end else
                cap = bus.in_valid;
        end else if (cnt_q == 2'd0) begin
            state_d = IDLE;
            cap = 1'b1;
        end else
            cnt_d = cnt_q - 2'd1;
        out_valid_d = cap;
        wbo_d = cap ? (mis ? '0 : bus.wbi) : wbo_q;
        dfm_d = cap ? (bus.mem_read & ~mis ? ld : '0) : dfm_q;
        dfi_d = cap ? bus.addr : dfi_q;
        ra_d = cap ? bus.regaddr : ra_q;
        mis_d = cap ? mis : mis_q;
    end

    always_ff @(posedge clk)
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            out_valid_q <= 1'b0;
            wbo_q <= '0;
            dfm_q <= '0;
            dfi_q <= '0;
            ra_q <= '0;
            mis_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            out_valid_q <= out_valid_d;
            wbo_q <= wbo_d;
            dfm_q <= dfm_d;
            dfi_q <= dfi_d;
            ra_q <= ra_d;
            mis_q <= mis_d;
        end

    assign bus.stall = (state_q == IDLE & slow_load) | (state_q == WAIT & cnt_q != 2'd0);
    assign bus.out_valid = out_valid_q;
    assign bus.wbo = wbo_q;
    assign bus.datafrommem = dfm_q;
    assign bus.datafromimm = dfi_q;
    assign bus.regaddrout = ra_q;
    assign bus.misaligned = mis_q;
endmodule

// File: tb/tb_mem_stage_pl.sv
// tb_mem_stage_pl: scoreboard bench for mem_stage_pl at LATENCY 1, 3 and 4 against a byte-array model.
module tb_mem_stage_pl;
    localparam int NB = 4 * (2**13);

    typedef struct {
        logic [1:0]  wbi;
        logic [4:0]  ra;
        logic        rd, wr;
        logic [1:0]  size;
        logic        sx;
        logic [31:0] addr, sd;
        logic        forw;
        logic [31:0] rfm;
    } op_t;

    typedef struct {
        int          cyc;
        logic [1:0]  wbo;
        logic [31:0] dfm, dfi;
        logic [4:0]  ra;
        logic        mis;
    } exp_t;

    logic clk = 1'b0, r1 = 1'b1, r3 = 1'b1, r4 = 1'b1;
    int cyc = 0, checks = 0, passes = 0;
    logic [7:0] mref [2][NB];
    exp_t q1[$], q3[$];

    mem_stage_pl_if #(.WB_W(2)) b1 ();
    mem_stage_pl_if #(.WB_W(2)) b3 ();
    mem_stage_pl_if #(.WB_W(2)) b4 ();

    mem_stage_pl #(.ADDR_W(13), .WB_W(2), .LATENCY(1)) d1 (.clk(clk), .reset(r1), .bus(b1));
    mem_stage_pl #(.ADDR_W(13), .WB_W(2), .LATENCY(3)) d3 (.clk(clk), .reset(r3), .bus(b3));
    mem_stage_pl #(.ADDR_W(13), .WB_W(2), .LATENCY(4)) d4 (.clk(clk), .reset(r4), .bus(b4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic op_t mk(logic rd, logic wr, logic [1:0] sz, logic sx, logic [31:0] a,
                               logic [31:0] sd, logic fw, logic [31:0] rfm);
        op_t o;
        o.wbi = 2'($urandom_range(1, 3));
        o.ra = 5'($urandom);
        o.rd = rd; o.wr = wr; o.size = sz; o.sx = sx;
        o.addr = a; o.sd = sd; o.forw = fw; o.rfm = rfm;
        return o;
    endfunction

    function automatic op_t rnd();
        int t;
        logic [31:0] a;
        t = $urandom_range(0, 3);
        a = ($urandom & 32'hFFFF8000) | 32'($urandom_range(0, 255));
        return mk(t == 0 || t == 3, t == 1, 2'($urandom), 1'($urandom), a, $urandom, 1'($urandom), $urandom);
    endfunction

    // Model memory is a flat little-endian byte array indexed by the wrapped byte address.
    function automatic exp_t predict(int k, op_t o, int lat);
        exp_t e;
        int ba, n;
        logic [31:0] v, wd;
        logic mis;
        mis = (o.rd || o.wr) && ((o.size == 2'd1 && o.addr[0]) || (o.size[1] && o.addr[1:0] != 2'd0));
        ba = int'(o.addr & 32'(NB - 1));
        n = o.size[1] ? 4 : o.size[0] ? 2 : 1;
        wd = o.forw ? o.rfm : o.sd;
        e.cyc = cyc + ((o.rd && !mis && lat > 1) ? lat : 1);
        e.wbo = mis ? 2'd0 : o.wbi;
        e.dfi = o.addr;
        e.ra = o.ra;
        e.mis = mis;
        e.dfm = 32'd0;
        if (!mis && o.rd) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mref[k][ba + i];
            if (o.sx && n < 4 && v[8*n - 1])
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            e.dfm = v;
        end
        if (!mis && o.wr)
            for (int i = 0; i < n; i++) mref[k][ba + i] = wd[8*i +: 8];
        return e;
    endfunction

    task automatic drive(int k, op_t o, logic v);
        if (k == 0)
            {b1.in_valid, b1.wbi, b1.regaddr, b1.mem_read, b1.mem_write, b1.size, b1.sign_ext,
             b1.addr, b1.store_data, b1.forw, b1.result_from_mem} =
            {v, o.wbi, o.ra, o.rd, o.wr, o.size, o.sx, o.addr, o.sd, o.forw, o.rfm};
        else if (k == 1)
            {b3.in_valid, b3.wbi, b3.regaddr, b3.mem_read, b3.mem_write, b3.size, b3.sign_ext,
             b3.addr, b3.store_data, b3.forw, b3.result_from_mem} =
            {v, o.wbi, o.ra, o.rd, o.wr, o.size, o.sx, o.addr, o.sd, o.forw, o.rfm};
        else
            {b4.in_valid, b4.wbi, b4.regaddr, b4.mem_read, b4.mem_write, b4.size, b4.sign_ext,
             b4.addr, b4.store_data, b4.forw, b4.result_from_mem} =
            {v, o.wbi, o.ra, o.rd, o.wr, o.size, o.sx, o.addr, o.sd, o.forw, o.rfm};
    endtask

    function automatic logic stall_of(int k);
        return k == 0 ? b1.stall : k == 1 ? b3.stall : b4.stall;
    endfunction

    // Present one instruction and hold it until stall drops; the expectation is queued up front.
    task automatic issue(int k, op_t o);
        exp_t e;
        int ns, lat;
        logic st;
        ns = 0;
        lat = k == 0 ? 1 : 3;
        e = predict(k, o, lat);
        if (k == 0) q1.push_back(e); else q3.push_back(e);
        drive(k, o, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            st = stall_of(k);
            ns += int'(st);
            @(posedge clk);
            #1;
            if (!st) break;
        end
        chk($sformatf("d%0d_stall_cycles", lat), 32'(ns), 32'((o.rd && !e.mis && lat > 1) ? lat - 1 : 0));
    endtask

    task automatic idle(int k);
        drive(k, rnd(), 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(string t, exp_t e, logic [1:0] wbo, logic [31:0] dfm, logic [31:0] dfi,
                       logic [4:0] ra, logic mis);
        chk({t, "_cycle"}, 32'(cyc), 32'(e.cyc));
        chk({t, "_wbo"}, 32'(wbo), 32'(e.wbo));
        chk({t, "_datafrommem"}, dfm, e.dfm);
        chk({t, "_datafromimm"}, dfi, e.dfi);
        chk({t, "_regaddrout"}, 32'(ra), 32'(e.ra));
        chk({t, "_misaligned"}, 32'(mis), 32'(e.mis));
    endtask

    always @(negedge clk)
        if (b1.out_valid) begin
            if (q1.size() == 0) chk("d1_unexpected_valid", 32'(b1.out_valid), 32'd0);
            else cmp("d1", q1.pop_front(), b1.wbo, b1.datafrommem, b1.datafromimm, b1.regaddrout, b1.misaligned);
        end

    always @(negedge clk)
        if (b3.out_valid) begin
            if (q3.size() == 0) chk("d3_unexpected_valid", 32'(b3.out_valid), 32'd0);
            else cmp("d3", q3.pop_front(), b3.wbo, b3.datafrommem, b3.datafromimm, b3.regaddrout, b3.misaligned);
        end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        op_t o;
        int t0, nv;
        logic st, got;
        for (int k = 0; k < 3; k++) drive(k, mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(b3.out_valid), 32'd0);
        chk("rst_wbo", 32'(b3.wbo), 32'd0);
        chk("rst_datafrommem", b3.datafrommem, 32'd0);
        chk("rst_datafromimm", b3.datafromimm, 32'd0);
        chk("rst_regaddrout", 32'(b3.regaddrout), 32'd0);
        chk("rst_misaligned", 32'(b3.misaligned), 32'd0);
        chk("rst_stall", 32'(b3.stall), 32'd0);
        chk("rst_d1_out_valid", 32'(b1.out_valid), 32'd0);
        r1 = 1'b0; r3 = 1'b0; r4 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 64; w++) issue(k, mk(0, 1, 2'd2, 0, 32'(w * 4), $urandom, 0, 0));
            issue(k, mk(0, 1, 2'd2, 0, 32'h40, 32'hDEADBEEF, 0, 0));
            issue(k, mk(1, 0, 2'd2, 0, 32'h40, 0, 0, 0));
            issue(k, mk(0, 1, 2'd0, 0, 32'h41, 32'h00000080, 0, 0));
            issue(k, mk(1, 0, 2'd0, 1, 32'h41, 0, 0, 0));
            issue(k, mk(1, 0, 2'd0, 0, 32'h41, 0, 0, 0));
            issue(k, mk(1, 0, 2'd2, 0, 32'h40, 0, 0, 0));
            issue(k, mk(0, 1, 2'd1, 0, 32'h42, 32'h00001234, 0, 0));
            issue(k, mk(1, 0, 2'd1, 0, 32'h42, 0, 0, 0));
            issue(k, mk(0, 1, 2'd2, 0, 32'h80, 32'h0, 1, 32'hCAFEF00D));
            issue(k, mk(1, 0, 2'd2, 0, 32'h80, 0, 0, 0));
            issue(k, mk(1, 0, 2'd2, 0, 32'h42, 0, 0, 0));
            issue(k, mk(0, 1, 2'd1, 0, 32'h43, 32'hFFFF, 0, 0));
            issue(k, mk(1, 0, 2'd3, 1, 32'h40, 0, 0, 0));
            issue(k, mk(0, 0, 2'd2, 0, 32'h12345678, 0, 0, 0));
            idle(k);
            issue(k, mk(1, 0, 2'd2, 0, 32'h00010040, 0, 0, 0));
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 7) == 0) idle(k);
                issue(k, rnd());
            end
            idle(k);
        end
        o = mk(0, 1, 2'd2, 0, 32'h10, 32'h11223344, 0, 0);
        drive(2, o, 1'b1);
        @(posedge clk);
        #1;
        chk("d4_store_valid", 32'(b4.out_valid), 32'd1);
        o = mk(1, 0, 2'd2, 0, 32'h10, 0, 0, 0);
        drive(2, o, 1'b1);
        @(negedge clk);
        chk("d4_load_stall", 32'(b4.stall), 32'd1);
        @(posedge clk);
        #1;
        r4 = 1'b1;
        drive(2, o, 1'b0);
        @(posedge clk);
        #1;
        r4 = 1'b0;
        chk("d4_rst_stall", 32'(b4.stall), 32'd0);
        chk("d4_rst_out_valid", 32'(b4.out_valid), 32'd0);
        chk("d4_rst_wbo", 32'(b4.wbo), 32'd0);
        chk("d4_rst_datafrommem", b4.datafrommem, 32'd0);
        chk("d4_rst_datafromimm", b4.datafromimm, 32'd0);
        chk("d4_rst_regaddrout", 32'(b4.regaddrout), 32'd0);
        chk("d4_rst_misaligned", 32'(b4.misaligned), 32'd0);
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            nv += int'(b4.out_valid);
        end
        chk("d4_no_pulse_after_reset", 32'(nv), 32'd0);
        @(posedge clk);
        #1;
        drive(2, o, 1'b1);
        t0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (b4.out_valid) begin
                got = 1'b1;
                chk("d4_readback_data", b4.datafrommem, 32'h11223344);
                chk("d4_readback_latency", 32'(cyc - t0), 32'd4);
            end
            st = b4.stall;
            @(posedge clk);
            #1;
            if (!st) drive(2, o, 1'b0);
        end
        chk("d4_readback_seen", 32'(got), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("d1_queue_drained", 32'(q1.size()), 32'd0);
        chk("d3_queue_drained", 32'(q3.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
